// File: rtl/icache_data_array_if.sv
// Purpose : read and refill signal bundle for icache_data_array (read port, refill beat stream).
// Latency : n/a (wiring only).
// Backpressure: fill beats move on fill_valid_i & fill_ready_o; reads are never stalled.
//
// Ports (names seen from the data array):
//   rd_req_i/rd_index_i/rd_beat_i    read request, all ways read at {index, beat}
//   rd_hit_i                         one-hot hit vector, valid the cycle after rd_req_i
//   rd_valid_o/rd_data_o             selected data, one cycle after the request
//   rd_parity_err_o                  byte parity mismatch on any hit way (parity builds only)
//   fill_start_i/_index_i/_way_i/_beat_i   start a refill, captured at start
//   fill_valid_i/fill_data_i/fill_ready_o  refill beat stream
//   fill_busy_o/fill_done_o          refill status
interface icache_data_array_if #(
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 8,
    parameter int WAYS    = 2,
    parameter int BEATS   = 4
) ();
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                rd_req_i;
    logic [INDEX_W-1:0]  rd_index_i;
    logic [BEAT_W-1:0]   rd_beat_i;
    logic [WAYS-1:0]     rd_hit_i;
    logic                rd_valid_o;
    logic [DATA_W-1:0]   rd_data_o;
    logic                rd_parity_err_o;

    logic                fill_start_i;
    logic [INDEX_W-1:0]  fill_index_i;
    logic [WAY_W-1:0]    fill_way_i;
    logic [BEAT_W-1:0]   fill_beat_i;
    logic                fill_valid_i;
    logic [DATA_W-1:0]   fill_data_i;
    logic                fill_ready_o;
    logic                fill_busy_o;
    logic                fill_done_o;

    // Data array side
    modport slave (
        input  rd_req_i, rd_index_i, rd_beat_i, rd_hit_i,
        output rd_valid_o, rd_data_o, rd_parity_err_o,
        input  fill_start_i, fill_index_i, fill_way_i, fill_beat_i,
        input  fill_valid_i, fill_data_i,
        output fill_ready_o, fill_busy_o, fill_done_o
    );

    // Requester / refill engine side
    modport master (
        output rd_req_i, rd_index_i, rd_beat_i, rd_hit_i,
        input  rd_valid_o, rd_data_o, rd_parity_err_o,
        output fill_start_i, fill_index_i, fill_way_i, fill_beat_i,
        output fill_valid_i, fill_data_i,
        input  fill_ready_o, fill_busy_o, fill_done_o
    );
endinterface

// File: rtl/icache_data_array.sv
// Purpose : multi-way I-cache data store with critical-beat-first line refill sequencer.
// Latency : reads return 1 cycle after rd_req_i; fill_done_o pulses 1 cycle after the last beat is written.
// Backpressure: fill_ready_o drops whenever rd_req_i is high (reads own the single RAM port per way).
//
// Ports: clk_i, rst_ni (async active-low), bus (icache_data_array_if.slave, see interface header).
// Optional macro ICACHE_DATA_PARITY_EN: adds one even-parity bit per byte per beat, computed on
// refill write and checked on read across the hit ways; when undefined rd_parity_err_o is 0.
module icache_data_array #(
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 8,
    parameter int WAYS    = 2,
    parameter int BEATS   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    icache_data_array_if.slave  bus
);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AW     = INDEX_W + BEAT_W;
    localparam int DEPTH  = 1 << AW;
    localparam int NBYTES = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Refill sequencer state
    logic [1:0]         r_state;
    logic [INDEX_W-1:0] r_index;
    logic [WAY_W-1:0]   r_way;
    logic [BEAT_W-1:0]  r_cnt;
    logic [BEAT_W:0]    r_left;

    // Storage and read pipeline
    logic [DATA_W-1:0]  r_mem [WAYS][DEPTH];
    logic [DATA_W-1:0]  r_rdq [WAYS];
    logic               r_rd_vld;
    logic [DATA_W-1:0]  r_hold;

    logic               w_wr;
    logic [AW-1:0]      w_waddr;
    logic [AW-1:0]      w_raddr;
    logic [DATA_W-1:0]  w_sel;

    assign w_wr    = (r_state == S_FILL) && bus.fill_valid_i && !bus.rd_req_i;
    assign w_waddr = {r_index, r_cnt};
    assign w_raddr = {bus.rd_index_i, bus.rd_beat_i};

    assign bus.fill_ready_o = (r_state == S_FILL) && !bus.rd_req_i;
    assign bus.fill_busy_o  = (r_state == S_FILL);
    assign bus.fill_done_o  = (r_state == S_DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_way   <= '0;
            r_cnt   <= '0;
            r_left  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.fill_start_i) begin
                        r_index <= bus.fill_index_i;
                        r_way   <= bus.fill_way_i;
                        r_cnt   <= bus.fill_beat_i;
                        r_left  <= (BEAT_W+1)'(BEATS);
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_wr) begin
                        // BEATS is a power of two, so natural overflow wraps the line
                        r_cnt  <= r_cnt + 1'b1;
                        r_left <= r_left - 1'b1;
                        if (r_left == (BEAT_W+1)'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM: one port per way, read when requested, otherwise the refill write may use it
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_way][w_waddr] <= bus.fill_data_i;
        end
        if (bus.rd_req_i) begin
            for (int w = 0; w < WAYS; w++) begin
                r_rdq[w] <= r_mem[w][w_raddr];
            end
        end
    end

    // Hit vector arrives a cycle after the request, so way selection is combinational on the output
    always_comb begin
        w_sel = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.rd_hit_i[w]) begin
                w_sel = w_sel | r_rdq[w];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_vld <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_rd_vld <= bus.rd_req_i;
            if (r_rd_vld) begin
                r_hold <= w_sel;
            end
        end
    end

    // Outside the valid cycle the last delivered word is replayed
    assign bus.rd_valid_o = r_rd_vld;
    assign bus.rd_data_o  = r_rd_vld ? w_sel : r_hold;

`ifdef ICACHE_DATA_PARITY_EN
    logic [NBYTES-1:0]  r_par  [WAYS][DEPTH];
    logic [NBYTES-1:0]  r_parq [WAYS];
    logic               w_perr;

    function automatic logic [NBYTES-1:0] f_byte_par(input logic [DATA_W-1:0] d);
        logic [NBYTES-1:0] p;
        for (int b = 0; b < NBYTES; b++) begin
            p[b] = ^d[b*8 +: 8];
        end
        return p;
    endfunction

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_par[r_way][w_waddr] <= f_byte_par(bus.fill_data_i);
        end
        if (bus.rd_req_i) begin
            for (int w = 0; w < WAYS; w++) begin
                r_parq[w] <= r_par[w][w_raddr];
            end
        end
    end

    always_comb begin
        w_perr = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (bus.rd_hit_i[w] && (|(r_parq[w] ^ f_byte_par(r_rdq[w])))) begin
                w_perr = 1'b1;
            end
        end
    end

    assign bus.rd_parity_err_o = r_rd_vld && w_perr;
`else
    assign bus.rd_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_icache_data_array.sv
module tb_icache_data_array;
    localparam int DATA_W  = 64;
    localparam int INDEX_W = 8;
    localparam int WAYS    = 2;
    localparam int BEATS   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_data_array_if #(.DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(WAYS), .BEATS(BEATS)) bus ();

    icache_data_array #(.DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(WAYS), .BEATS(BEATS)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: per-way line store addressed by set*BEATS+beat, with a written flag
    logic [DATA_W-1:0] m_mem   [0:WAYS-1][0:1023];
    bit                m_known [0:WAYS-1][0:1023];
    logic [DATA_W-1:0] fbuf    [0:BEATS-1];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.rd_req_i     = 1'b0;
        bus.rd_index_i   = '0;
        bus.rd_beat_i    = '0;
        bus.rd_hit_i     = '0;
        bus.fill_start_i = 1'b0;
        bus.fill_index_i = '0;
        bus.fill_way_i   = '0;
        bus.fill_beat_i  = '0;
        bus.fill_valid_i = 1'b0;
        bus.fill_data_i  = '0;
    endtask

    task automatic rand_fbuf();
        for (int k = 0; k < BEATS; k++) fbuf[k] = {$urandom, $urandom};
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({bus.rd_valid_o, bus.rd_parity_err_o, bus.fill_ready_o, bus.fill_busy_o, bus.fill_done_o} !== 5'b0
            || bus.rd_data_o !== '0) begin
            n_fail++;
            $display("FAIL %s: vld=%b perr=%b rdy=%b busy=%b done=%b data=%h, required all 0",
                     tag, bus.rd_valid_o, bus.rd_parity_err_o, bus.fill_ready_o,
                     bus.fill_busy_o, bus.fill_done_o, bus.rd_data_o);
        end
    endtask

    // Read one beat; the hit vector is applied in the cycle after the request
    task automatic do_read(input int idx, input int beat, input logic [WAYS-1:0] hit,
                           input logic exp_perr, input string tag);
        logic [DATA_W-1:0] exp;
        bit known;
        int a;
        a = idx * BEATS + beat;
        @(negedge clk);
        bus.rd_req_i   = 1'b1;
        bus.rd_index_i = INDEX_W'(idx);
        bus.rd_beat_i  = 2'(beat);
        @(negedge clk);
        bus.rd_req_i = 1'b0;
        bus.rd_hit_i = hit;
        #1;
        exp = '0;
        known = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (hit[w]) begin
                if (!m_known[w][a]) known = 1'b0;
                exp = exp | m_mem[w][a];
            end
        end
        n_checks++;
        if (bus.rd_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s rd_valid: got %b want 1", tag, bus.rd_valid_o);
        end
        if (known) begin
            n_checks++;
            if (bus.rd_data_o !== exp) begin
                n_fail++;
                $display("FAIL %s rd_data idx=%0d beat=%0d hit=%b: got %h want %h",
                         tag, idx, beat, hit, bus.rd_data_o, exp);
            end
            n_checks++;
            if (bus.rd_parity_err_o !== exp_perr) begin
                n_fail++;
                $display("FAIL %s rd_parity_err: got %b want %b", tag, bus.rd_parity_err_o, exp_perr);
            end
        end
        @(negedge clk);
        bus.rd_hit_i = '0;
        #1;
        n_checks++;
        if (bus.rd_valid_o !== 1'b0 || (known && bus.rd_data_o !== exp)) begin
            n_fail++;
            $display("FAIL %s hold: vld=%b data=%h want vld=0 data=%h", tag, bus.rd_valid_o, bus.rd_data_o, exp);
        end
    endtask

    // Full refill of fbuf; optionally hold rd_req_i for 3 cycles just before beat stall_at
    task automatic do_fill(input int idx, input int way, input int cb, input int stall_at, input string tag);
        int guard;
        @(negedge clk);
        bus.fill_start_i = 1'b1;
        bus.fill_index_i = INDEX_W'(idx);
        bus.fill_way_i   = 1'(way);
        bus.fill_beat_i  = 2'(cb);
        @(negedge clk);
        bus.fill_start_i = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            bus.fill_valid_i = 1'b1;
            bus.fill_data_i  = fbuf[k];
            if (k == stall_at) begin
                bus.rd_req_i   = 1'b1;
                bus.rd_index_i = INDEX_W'($urandom);
                repeat (3) begin
                    #1;
                    n_checks++;
                    if (bus.fill_ready_o !== 1'b0 || bus.fill_busy_o !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s stall: rdy=%b busy=%b want rdy=0 busy=1",
                                 tag, bus.fill_ready_o, bus.fill_busy_o);
                    end
                    @(negedge clk);
                end
                bus.rd_req_i = 1'b0;
            end
            #1;
            guard = 0;
            while (bus.fill_ready_o !== 1'b1 && guard < 20) begin
                @(negedge clk);
                #1;
                guard++;
            end
            n_checks++;
            if (bus.fill_ready_o !== 1'b1 || bus.fill_busy_o !== 1'b1 || bus.fill_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s beat %0d accept: rdy=%b busy=%b done=%b want 1/1/0",
                         tag, k, bus.fill_ready_o, bus.fill_busy_o, bus.fill_done_o);
            end
            @(negedge clk);
            m_mem[way][idx * BEATS + ((cb + k) % BEATS)]   = fbuf[k];
            m_known[way][idx * BEATS + ((cb + k) % BEATS)] = 1'b1;
        end
        bus.fill_valid_i = 1'b0;
        #1;
        n_checks++;
        if (bus.fill_done_o !== 1'b1 || bus.fill_busy_o !== 1'b0 || bus.fill_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done pulse: done=%b busy=%b rdy=%b want 1/0/0",
                     tag, bus.fill_done_o, bus.fill_busy_o, bus.fill_ready_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fill_done_o !== 1'b0 || bus.fill_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done width: done=%b busy=%b want 0/0", tag, bus.fill_done_o, bus.fill_busy_o);
        end
    endtask

    task automatic test_reset();
        #12;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fill_ready_o !== 1'b0 || bus.fill_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b busy=%b want 0/0", bus.fill_ready_o, bus.fill_busy_o);
        end
        // Idle fill_valid_i must not be accepted
        bus.fill_valid_i = 1'b1;
        #1;
        n_checks++;
        if (bus.fill_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid: rdy=%b want 0", bus.fill_ready_o);
        end
        bus.fill_valid_i = 1'b0;
        // Put the block in a busy, read-valid state and pull reset between edges
        @(negedge clk);
        bus.fill_start_i = 1'b1;
        @(negedge clk);
        bus.fill_start_i = 1'b0;
        bus.rd_req_i     = 1'b1;
        @(posedge clk);
        #2;
        n_checks++;
        if (bus.rd_valid_o !== 1'b1 || bus.fill_busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async_reset: vld=%b busy=%b want 1/1", bus.rd_valid_o, bus.fill_busy_o);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        bus.rd_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_crit_fill();
        rand_fbuf();
        do_fill(5, 1, 2, -1, "crit_fill");
    endtask

    task automatic test_read_after_fill();
        do_read(5, 0, 2'b10, 1'b0, "raf_beat0_hit10");
        do_read(5, 0, 2'b00, 1'b0, "raf_beat0_hit00");
        for (int b = 1; b < BEATS; b++) do_read(5, b, 2'b10, 1'b0, "raf_line");
    endtask

    task automatic test_contention();
        rand_fbuf();
        do_fill(9, 0, 1, 1, "contention");
        for (int b = 0; b < BEATS; b++) do_read(9, b, 2'b01, 1'b0, "contention_rd");
    endtask

    task automatic test_reset_mid_fill();
        rand_fbuf();
        @(negedge clk);
        bus.fill_start_i = 1'b1;
        bus.fill_index_i = 8'd12;
        bus.fill_way_i   = 1'b0;
        bus.fill_beat_i  = 2'd3;
        @(negedge clk);
        bus.fill_start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.fill_valid_i = 1'b1;
            bus.fill_data_i  = fbuf[k];
            @(negedge clk);
            m_mem[0][12 * BEATS + ((3 + k) % BEATS)]   = fbuf[k];
            m_known[0][12 * BEATS + ((3 + k) % BEATS)] = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midfill_reset");
        bus.fill_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.fill_done_o !== 1'b0 || bus.fill_busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midfill_after: done=%b busy=%b want 0/0", bus.fill_done_o, bus.fill_busy_o);
            end
        end
        rand_fbuf();
        do_fill(13, 1, 0, -1, "refill_after_reset");
        do_read(12, 3, 2'b01, 1'b0, "midfill_kept3");
        do_read(12, 0, 2'b01, 1'b0, "midfill_kept0");
        do_read(13, 2, 2'b10, 1'b0, "refill_rd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rand_fbuf();
                do_fill($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                        $urandom_range(0, 5) - 2, "rand_fill");
            end else begin
                do_read($urandom_range(0, 7), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                        1'b0, "rand_read");
            end
        end
    endtask

`ifdef ICACHE_DATA_PARITY_EN
    task automatic test_parity();
        int a;
        rand_fbuf();
        do_fill(20, 1, 0, -1, "par_fill");
        a = 20 * BEATS + 2;
        dut.r_mem[1][a][13] = ~dut.r_mem[1][a][13];
        m_mem[1][a][13] = ~m_mem[1][a][13];
        do_read(20, 2, 2'b10, 1'b1, "par_flipped");
        do_read(20, 1, 2'b10, 1'b0, "par_clean");
        do_read(20, 2, 2'b00, 1'b0, "par_nohit");
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_crit_fill();
        test_read_after_fill();
        test_contention();
        test_reset_mid_fill();
        test_random();
`ifdef ICACHE_DATA_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
